// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART interrupt service controller: register map,
// IIR interrupt codes and the controller / APB sequencing state encodings.
package uart_ctrl_pkg;

  localparam logic [4:0] ADDR_DR   = 5'd0;
  localparam logic [4:0] ADDR_IER  = 5'd1;
  localparam logic [4:0] ADDR_IIR  = 5'd2;
  localparam logic [4:0] ADDR_FCR  = 5'd2;
  localparam logic [4:0] ADDR_LCR  = 5'd3;
  localparam logic [4:0] ADDR_LSR  = 5'd5;
  localparam logic [4:0] ADDR_MSR  = 5'd6;
  localparam logic [4:0] ADDR_DIV1 = 5'd7;
  localparam logic [4:0] ADDR_DIV2 = 5'd8;

  localparam logic [3:0] IIR_LS   = 4'd6;
  localparam logic [3:0] IIR_RX   = 4'd4;
  localparam logic [3:0] IIR_TX   = 4'd2;
  localparam logic [3:0] IIR_MS   = 4'd0;
  localparam logic [3:0] IIR_NONE = 4'd1;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_INIT,
    ST_WAIT_IRQ,
    ST_RD_IIR,
    ST_DISPATCH,
    ST_RX_LSR,
    ST_RX_DR,
    ST_RX_HOLD,
    ST_TX_WR,
    ST_LS_RD,
    ST_MS_RD
  } ctrl_state_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  // Register written at each step of the five-write init sequence.
  function automatic logic [4:0] init_addr(input logic [2:0] step);
    case (step)
      3'd0:    return ADDR_DIV1;
      3'd1:    return ADDR_DIV2;
      3'd2:    return ADDR_LCR;
      3'd3:    return ADDR_FCR;
      default: return ADDR_IER;
    endcase
  endfunction

endpackage

// File: rtl/uart_apb_master.sv
// Single-outstanding APB master: SETUP, ACCESS until PREADY, then at least one
// idle cycle (IDLE) before the next request is accepted.
module uart_apb_master
  import uart_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [4:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  apb_state_e  state_q, state_d;
  logic        pwrite_q;
  logic [4:0]  paddr_q;
  logic [31:0] pwdata_q;
  logic        accept;
  logic        unused_prdata;

  assign accept = (state_q == APB_IDLE) && req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= APB_IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pwrite_q <= wr_i;
        paddr_q  <= addr_i;
        pwdata_q <= wdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      APB_IDLE:   if (req_i) state_d = APB_SETUP;
      APB_SETUP:  state_d = APB_ACCESS;
      APB_ACCESS: if (pready_i) state_d = APB_IDLE;
      default:    state_d = APB_IDLE;
    endcase
  end

  // Strobes decode straight from the state flops so reset drops them at once.
  assign psel_o        = (state_q != APB_IDLE);
  assign penable_o     = (state_q == APB_ACCESS);
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign busy_o        = psel_o;
  assign done_o        = penable_o && pready_i;
  assign err_o         = done_o && pslverr_i;
  assign rdata_o       = prdata_i[7:0];
  assign unused_prdata = ^prdata_i[31:8];

endmodule

// File: rtl/uart_irq_service_ctrl.sv
// Configures the UART over APB, then services its interrupt: RX drain to a
// byte stream, TX refill from a byte stream, line/modem status reporting.
module uart_irq_service_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_BURST = 16,
  parameter int RX_BURST = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  input  logic        irq,
  input  logic        cfg_start,
  input  logic [15:0] cfg_divisor,
  input  logic [7:0]  cfg_lcr,
  input  logic [7:0]  cfg_fcr,
  input  logic [3:0]  cfg_ier,
  output logic        init_done,
  output logic        busy,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        ls_valid,
  output logic [7:0]  ls_status,
  output logic        ms_valid,
  output logic [7:0]  ms_status,
  output logic        slverr
);

  localparam logic [4:0] TX_LIM = 5'(TX_BURST);
  localparam logic [4:0] RX_LIM = 5'(RX_BURST);

  ctrl_state_e state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  iir_q, iir_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        ls_valid_q, ls_valid_d;
  logic [7:0]  ls_status_q, ls_status_d;
  logic        ms_valid_q, ms_valid_d;
  logic [7:0]  ms_status_q, ms_status_d;
  logic        slverr_q, slverr_d;

  logic [15:0] div_q;
  logic [7:0]  lcr_q, fcr_q;
  logic [3:0]  ier_q;
  logic        cfg_load;
  logic [31:0] init_wdata;

  logic        apb_req, apb_wr, apb_done, apb_err, apb_busy;
  logic [4:0]  apb_addr;
  logic [31:0] apb_wdata;
  logic [7:0]  apb_rdata;

  uart_apb_master u_apb (
    .clk_i     (PCLK),
    .rst_ni    (PRESETn),
    .req_i     (apb_req),
    .wr_i      (apb_wr),
    .addr_i    (apb_addr),
    .wdata_i   (apb_wdata),
    .done_o    (apb_done),
    .rdata_o   (apb_rdata),
    .err_o     (apb_err),
    .busy_o    (apb_busy),
    .psel_o    (PSEL),
    .penable_o (PENABLE),
    .pwrite_o  (PWRITE),
    .paddr_o   (PADDR),
    .pwdata_o  (PWDATA),
    .prdata_i  (PRDATA),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_OFF;
      step_q      <= '0;
      cnt_q       <= '0;
      iir_q       <= '0;
      init_done_q <= 1'b0;
      rx_data_q   <= '0;
      ls_valid_q  <= 1'b0;
      ls_status_q <= '0;
      ms_valid_q  <= 1'b0;
      ms_status_q <= '0;
      slverr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      iir_q       <= iir_d;
      init_done_q <= init_done_d;
      rx_data_q   <= rx_data_d;
      ls_valid_q  <= ls_valid_d;
      ls_status_q <= ls_status_d;
      ms_valid_q  <= ms_valid_d;
      ms_status_q <= ms_status_d;
      slverr_q    <= slverr_d;
    end
  end

  // Configuration snapshot taken on the accepted cfg_start; no reset needed.
  always_ff @(posedge PCLK) begin
    if (cfg_load) begin
      div_q <= cfg_divisor;
      lcr_q <= cfg_lcr;
      fcr_q <= cfg_fcr;
      ier_q <= cfg_ier;
    end
  end

  always_comb begin
    init_wdata = '0;
    case (step_q)
      3'd0:    init_wdata[7:0] = div_q[7:0];
      3'd1:    init_wdata[7:0] = div_q[15:8];
      3'd2:    init_wdata[7:0] = lcr_q;
      3'd3:    init_wdata[7:0] = fcr_q;
      default: init_wdata[3:0] = ier_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    iir_d       = iir_q;
    init_done_d = init_done_q;
    rx_data_d   = rx_data_q;
    ls_valid_d  = 1'b0;
    ls_status_d = ls_status_q;
    ms_valid_d  = 1'b0;
    ms_status_d = ms_status_q;
    slverr_d    = slverr_q | apb_err;
    apb_req     = 1'b0;
    apb_wr      = 1'b0;
    apb_addr    = ADDR_DR;
    apb_wdata   = '0;
    tx_ready    = 1'b0;
    cfg_load    = 1'b0;

    unique case (state_q)
      ST_OFF: begin
        if (cfg_start) begin
          cfg_load = 1'b1;
          step_d   = '0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        apb_req   = 1'b1;
        apb_wr    = 1'b1;
        apb_addr  = init_addr(step_q);
        apb_wdata = init_wdata;
        if (apb_done) begin
          if (step_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = ST_WAIT_IRQ;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      ST_WAIT_IRQ: begin
        if (irq) state_d = ST_RD_IIR;
      end
      ST_RD_IIR: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_IIR;
        if (apb_done) begin
          iir_d   = apb_rdata[3:0];
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        cnt_d = '0;
        case (iir_q)
          IIR_LS:   state_d = ST_LS_RD;
          IIR_RX:   state_d = ST_RX_LSR;
          IIR_TX:   state_d = ST_TX_WR;
          IIR_MS:   state_d = ST_MS_RD;
          IIR_NONE: state_d = ST_WAIT_IRQ;
          default:  state_d = ST_WAIT_IRQ;
        endcase
      end
      ST_RX_LSR: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_LSR;
        if (apb_done) begin
          if (apb_rdata[4:1] != 4'd0) begin
            ls_valid_d  = 1'b1;
            ls_status_d = apb_rdata;
          end
          state_d = (apb_rdata[0] && (cnt_q < RX_LIM)) ? ST_RX_DR : ST_WAIT_IRQ;
        end
      end
      ST_RX_DR: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_DR;
        if (apb_done) begin
          rx_data_d = apb_rdata;
          state_d   = ST_RX_HOLD;
        end
      end
      ST_RX_HOLD: begin
        if (rx_ready) begin
          cnt_d   = cnt_q + 5'd1;
          state_d = ST_RX_LSR;
        end
      end
      ST_TX_WR: begin
        apb_wr    = 1'b1;
        apb_addr  = ADDR_DR;
        apb_wdata = {24'd0, tx_data};
        // Only decide on the next byte once the previous write has retired.
        if (!apb_busy) begin
          if (tx_valid && (cnt_q < TX_LIM)) apb_req = 1'b1;
          else                              state_d = ST_WAIT_IRQ;
        end
        if (apb_done) begin
          tx_ready = 1'b1;
          cnt_d    = cnt_q + 5'd1;
        end
      end
      ST_LS_RD: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_LSR;
        if (apb_done) begin
          ls_valid_d  = 1'b1;
          ls_status_d = apb_rdata;
          state_d     = ST_RX_LSR;
        end
      end
      ST_MS_RD: begin
        apb_req  = 1'b1;
        apb_addr = ADDR_MSR;
        if (apb_done) begin
          ms_valid_d  = 1'b1;
          ms_status_d = apb_rdata;
          state_d     = ST_WAIT_IRQ;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign init_done = init_done_q;
  assign busy      = apb_busy;
  assign rx_valid  = (state_q == ST_RX_HOLD);
  assign rx_data   = rx_data_q;
  assign ls_valid  = ls_valid_q;
  assign ls_status = ls_status_q;
  assign ms_valid  = ms_valid_q;
  assign ms_status = ms_status_q;
  assign slverr    = slverr_q;

endmodule

// File: tb/tb_uart_irq_service_ctrl.sv
// Scoreboard bench for uart_irq_service_ctrl: an APB slave model answers from a
// queue of expected transfers; stream and status outputs are popped by monitors.
module tb_uart_irq_service_ctrl;

  logic        PCLK, PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR, irq, cfg_start;
  logic [15:0] cfg_divisor;
  logic [7:0]  cfg_lcr, cfg_fcr;
  logic [3:0]  cfg_ier;
  logic        init_done, busy, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data, ls_status, ms_status;
  logic        ls_valid, ms_valid, slverr;

  uart_irq_service_ctrl #(.TX_BURST(16), .RX_BURST(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq(irq), .cfg_start(cfg_start), .cfg_divisor(cfg_divisor), .cfg_lcr(cfg_lcr),
    .cfg_fcr(cfg_fcr), .cfg_ier(cfg_ier), .init_done(init_done), .busy(busy),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .ls_valid(ls_valid), .ls_status(ls_status),
    .ms_valid(ms_valid), .ms_status(ms_status), .slverr(slverr)
  );

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] data;
    logic        err;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] ls_q[$];
  logic [7:0] ms_q[$];
  logic [7:0] tx_src[$];

  int          checks = 0;
  int          failures = 0;
  int          apb_waits = 0;
  int          wcnt = 0;
  int          iir_reads = 0;
  int          tx_acc = 0;
  int          tx_taken = 0;
  logic        prev_psel = 1'b0;
  logic [4:0]  setup_addr;
  logic        setup_wr;
  logic [31:0] setup_wdata;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [63:0] val);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event with value 0x%0h, none required", name, val);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #2;
    end
  endtask

  task automatic exp_apb(input logic [4:0] a, input logic w, input logic [31:0] d, input logic e);
    apb_exp_t x;
    x.addr = a; x.wr = w; x.data = d; x.err = e;
    apb_q.push_back(x);
  endtask

  // APB slave: answers each ACCESS from the head of the expected-transfer queue.
  always begin
    @(posedge PCLK);
    #1;
    if (!PRESETn) begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; wcnt = 0; prev_psel = 1'b0;
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      if (PSEL && !PENABLE) begin
        chk("apb_idle_gap_before_setup", prev_psel, 1'b0);
        setup_addr = PADDR; setup_wr = PWRITE; setup_wdata = PWDATA;
      end else if (PSEL && PENABLE) begin
        if (wcnt < apb_waits) begin
          wcnt++;
        end else begin
          wcnt = 0;
          PREADY = 1'b1;
          if (apb_q.size() == 0) begin
            unexp("apb_transfer", {PWRITE, PADDR, PWDATA});
          end else begin
            apb_exp_t e;
            e = apb_q.pop_front();
            chk("apb_addr", PADDR, e.addr);
            chk("apb_write", PWRITE, e.wr);
            if (e.wr) chk("apb_wdata", PWDATA, e.data);
            chk("apb_stable_setup_to_ready", {PADDR, PWRITE, PWDATA},
                {setup_addr, setup_wr, setup_wdata});
            PRDATA  = e.wr ? 32'h0 : e.data;
            PSLVERR = e.err;
            if (!e.wr && e.addr == 5'd2) iir_reads++;
          end
        end
      end
      prev_psel = PSEL;
    end
  end

  // TX byte source: advances after each observed tx_ready handshake.
  always begin
    @(posedge PCLK);
    #1;
    while (tx_taken < tx_acc) begin
      if (tx_src.size() > 0) void'(tx_src.pop_front());
      tx_taken++;
    end
    tx_valid = (tx_src.size() > 0);
    tx_data  = tx_valid ? tx_src[0] : 8'h00;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (tx_ready) begin
        tx_acc++;
        chk("tx_ready_only_with_valid", tx_valid, 1'b1);
      end
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) unexp("rx_byte", rx_data);
        else                  chk("rx_byte", rx_data, rx_q.pop_front());
      end
      if (ls_valid) begin
        if (ls_q.size() == 0) unexp("ls_status", ls_status);
        else                  chk("ls_status", ls_status, ls_q.pop_front());
      end
      if (ms_valid) begin
        if (ms_q.size() == 0) unexp("ms_status", ms_status);
        else                  chk("ms_status", ms_status, ms_q.pop_front());
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int i = 0;
    while (apb_q.size() != 0 && i < budget) begin
      tick(1);
      i++;
    end
    checks++;
    if (apb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d transfers outstanding, required 0", name, apb_q.size());
    end
    tick(8);
    chk({name, "_rx_left"}, rx_q.size(), 0);
    chk({name, "_ls_left"}, ls_q.size(), 0);
    chk({name, "_ms_left"}, ms_q.size(), 0);
  endtask

  task automatic raise_irq(input string name);
    int start = iir_reads;
    int i = 0;
    irq = 1'b1;
    while (iir_reads == start && i < 100) begin
      tick(1);
      i++;
    end
    irq = 1'b0;
    chk({name, "_iir_read"}, (iir_reads != start), 1'b1);
  endtask

  task automatic start_cfg(input logic [15:0] d, input logic [7:0] l, input logic [7:0] f,
                           input logic [3:0] ie);
    cfg_divisor = d; cfg_lcr = l; cfg_fcr = f; cfg_ier = ie;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    cfg_divisor = 16'hFFFF; cfg_lcr = 8'hEE; cfg_fcr = 8'hDD; cfg_ier = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int psel_seen;
    int found;
    PRESETn = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; irq = 1'b0;
    cfg_start = 1'b0; cfg_divisor = '0; cfg_lcr = '0; cfg_fcr = '0; cfg_ier = '0;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    tick(3);
    PRESETn = 1'b1;
    tick(2);
    chk("reset_apb_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'h0);
    chk("reset_other_outputs", {init_done, busy, tx_ready, rx_valid, rx_data, ls_valid,
        ls_status, ms_valid, ms_status, slverr}, 64'h0);

    // Init sequence
    exp_apb(5'd7, 1'b1, 32'h45, 1'b0);
    exp_apb(5'd8, 1'b1, 32'h01, 1'b0);
    exp_apb(5'd3, 1'b1, 32'h1B, 1'b0);
    exp_apb(5'd2, 1'b1, 32'h80, 1'b0);
    exp_apb(5'd1, 1'b1, 32'h0F, 1'b0);
    start_cfg(16'h0145, 8'h1B, 8'h80, 4'hF);
    chk("init_done_during_init", init_done, 1'b0);
    drain("init", 100);
    chk("init_done", init_done, 1'b1);

    // cfg_start outside OFF must not start anything
    start_cfg(16'h2222, 8'h03, 8'h07, 4'h1);
    tick(10);
    chk("ignored_start_init_done", init_done, 1'b1);

    // RX drain with a stalled consumer
    apb_waits = 1;
    exp_apb(5'd2, 1'b0, 32'h4, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h01, 1'b0);
    exp_apb(5'd0, 1'b0, 32'h55, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h01, 1'b0);
    exp_apb(5'd0, 1'b0, 32'hAA, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h00, 1'b0);
    rx_q.push_back(8'h55);
    rx_q.push_back(8'hAA);
    raise_irq("rx");
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick(1);
      if (rx_valid) found = 1;
    end
    chk("rx_first_valid", found, 1);
    psel_seen = 0;
    repeat (10) begin
      tick(1);
      if (PSEL) psel_seen++;
    end
    chk("rx_hold_no_apb", psel_seen, 0);
    chk("rx_hold_valid", rx_valid, 1'b1);
    chk("rx_hold_data", rx_data, 8'h55);
    rx_ready = 1'b1;
    drain("rx", 200);

    // TX refill capped at 16 per interrupt
    apb_waits = 0;
    for (int i = 0; i < 20; i++) tx_src.push_back(8'(8'h10 + i));
    exp_apb(5'd2, 1'b0, 32'h2, 1'b0);
    for (int i = 0; i < 16; i++) exp_apb(5'd0, 1'b1, 32'(8'h10 + i), 1'b0);
    raise_irq("tx1");
    drain("tx1", 400);
    chk("tx1_bytes_left", tx_src.size(), 4);
    exp_apb(5'd2, 1'b0, 32'h2, 1'b0);
    for (int i = 0; i < 4; i++) exp_apb(5'd0, 1'b1, 32'(8'h20 + i), 1'b0);
    raise_irq("tx2");
    drain("tx2", 200);
    chk("tx2_bytes_left", tx_src.size(), 0);
    exp_apb(5'd2, 1'b0, 32'h2, 1'b0);
    raise_irq("tx_empty");
    drain("tx_empty", 100);

    // Line status, then RX drain continues (second LSR carries an error bit)
    exp_apb(5'd2, 1'b0, 32'h6, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h09, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h03, 1'b0);
    exp_apb(5'd0, 1'b0, 32'h3C, 1'b0);
    exp_apb(5'd5, 1'b0, 32'h00, 1'b0);
    ls_q.push_back(8'h09);
    ls_q.push_back(8'h03);
    rx_q.push_back(8'h3C);
    raise_irq("ls");
    drain("ls", 200);

    // Modem status with a slave error on the MSR read
    chk("slverr_before", slverr, 1'b0);
    exp_apb(5'd2, 1'b0, 32'h0, 1'b0);
    exp_apb(5'd6, 1'b0, 32'hB1, 1'b1);
    ms_q.push_back(8'hB1);
    raise_irq("ms");
    drain("ms", 100);
    chk("slverr_set", slverr, 1'b1);
    exp_apb(5'd2, 1'b0, 32'h1, 1'b0);
    raise_irq("none");
    drain("none", 100);
    exp_apb(5'd2, 1'b0, 32'hC, 1'b0);
    raise_irq("unknown_iir");
    drain("unknown_iir", 100);
    chk("slverr_sticky", slverr, 1'b1);

    // Asynchronous reset in the ACCESS phase of the DIV2 write
    PRESETn = 1'b0;
    tick(2);
    PRESETn = 1'b1;
    tick(2);
    chk("reset_clears_slverr_init_done", {slverr, init_done}, 2'b00);
    apb_waits = 3;
    exp_apb(5'd7, 1'b1, 32'h34, 1'b0);
    exp_apb(5'd8, 1'b1, 32'h12, 1'b0);
    start_cfg(16'h1234, 8'h03, 8'hC1, 4'h5);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PADDR == 5'd8) found = 1;
    end
    chk("div2_access_seen", found, 1);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("async_reset_outputs", {PSEL, PENABLE, busy, init_done, PADDR}, 64'h0);
    chk("div2_left_unfinished", apb_q.size(), 1);
    apb_q.delete();
    tick(2);
    PRESETn = 1'b1;
    apb_waits = 0;
    exp_apb(5'd7, 1'b1, 32'h34, 1'b0);
    exp_apb(5'd8, 1'b1, 32'h12, 1'b0);
    exp_apb(5'd3, 1'b1, 32'h03, 1'b0);
    exp_apb(5'd2, 1'b1, 32'hC1, 1'b0);
    exp_apb(5'd1, 1'b1, 32'h05, 1'b0);
    start_cfg(16'h1234, 8'h03, 8'hC1, 4'h5);
    drain("reinit", 100);
    chk("reinit_done", init_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
